// File: rtl/parking_pkg.sv
// parking_pkg: shared types and helpers for the parking lane arbiter.
package parking_pkg;

    localparam int LANES = 2;

    // One bit is enough to name either of the two entrance lanes.
    typedef logic lane_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WAIT,
        OPEN
    } arb_state_e;

    // Convert a lane index into its one-hot lane vector.
    function automatic logic [LANES-1:0] lane_onehot(input lane_idx_t lane);
        logic [LANES-1:0] v;
        v = '0;
        v[lane] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/parking_occupancy_ctr.sv
// parking_occupancy_ctr: lot occupancy counter clamped to 0..CAPACITY,
// with free_slots/full registered from the updated occupancy.
module parking_occupancy_ctr
    import parking_pkg::*;
#(
    parameter int CAPACITY = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           inc,
    input  logic                           dec,
    output logic [$clog2(CAPACITY+1)-1:0]  free_slots,
    output logic                           full
);

    localparam int CNT_W = $clog2(CAPACITY + 1);
    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] occ_next;

    // Next occupancy: simultaneous inc/dec cancel; dec at empty and inc at full are dropped.
    always_comb begin
        occ_next = occ;
        if (inc && !dec) begin
            if (occ != CAP) begin
                occ_next = occ + 1'b1;
            end
        end else if (dec && !inc) begin
            if (occ != '0) begin
                occ_next = occ - 1'b1;
            end
        end
    end

    // Occupancy register plus status outputs derived from the value being stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ        <= '0;
            free_slots <= CAP;
            full       <= 1'b0;
        end else begin
            occ        <= occ_next;
            free_slots <= CAP - occ_next;
            full       <= (occ_next == CAP);
        end
    end

endmodule

// File: rtl/parking_lane_arbiter.sv
// parking_lane_arbiter: round-robin arbiter sharing one password checker
// between two entrance lanes, with barrier/reject pulses and occupancy tracking.
// Optional macro PARKING_LANE_ARBITER_STATS_EN adds reject_count and timeout_seen.
module parking_lane_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY       = 8,
    parameter int OPEN_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     lane_req,
    input  logic                           exit_event,
    output logic                           chk_start,
    output logic                           chk_lane,
    input  logic                           chk_done,
    input  logic                           chk_pass,
    output logic [1:0]                     lane_grant,
    output logic [1:0]                     lane_open,
    output logic [1:0]                     lane_reject,
    output logic [$clog2(CAPACITY+1)-1:0]  free_slots,
    output logic                           full
`ifdef PARKING_LANE_ARBITER_STATS_EN
    ,
    output logic [7:0]                     reject_count,
    output logic                           timeout_seen
`endif
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam int OPEN_W  = $clog2(OPEN_CYCLES + 1);

    arb_state_e        state;
    lane_idx_t         lane;
    lane_idx_t         rr_ptr;
    lane_idx_t         pick;
    logic [TIMER_W-1:0] timer;
    logic [OPEN_W-1:0]  open_cnt;

    logic admit;
    logic timed_out;
    logic reject_now;

    // Round-robin choice: the pointer's lane if it is waiting, otherwise the other one.
    always_comb begin
        pick = rr_ptr;
        if (!lane_req[rr_ptr]) begin
            pick = ~rr_ptr;
        end
    end

    // The timeout fires on the edge where the timer would reach TIMEOUT_CYCLES-1;
    // a chk_done in that same cycle takes priority.
    always_comb begin
        admit      = (state == WAIT) && chk_done && chk_pass;
        timed_out  = (state == WAIT) && !chk_done && (timer == TIMER_W'(TIMEOUT_CYCLES - 2));
        reject_now = ((state == WAIT) && chk_done && !chk_pass) || timed_out;
    end

    // Arbitration FSM with registered handshake, grant, open and reject outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lane        <= '0;
            rr_ptr      <= '0;
            timer       <= '0;
            open_cnt    <= '0;
            chk_start   <= 1'b0;
            chk_lane    <= '0;
            lane_grant  <= '0;
            lane_open   <= '0;
            lane_reject <= '0;
        end else begin
            chk_start   <= 1'b0;
            lane_reject <= '0;
            unique case (state)
                IDLE: begin
                    if ((|lane_req) && !full) begin
                        lane       <= pick;
                        chk_lane   <= pick;
                        chk_start  <= 1'b1;
                        lane_grant <= lane_onehot(pick);
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (admit) begin
                        lane_open <= lane_onehot(lane);
                        open_cnt  <= '0;
                        state     <= OPEN;
                    end else if (reject_now) begin
                        lane_reject <= lane_onehot(lane);
                        lane_grant  <= '0;
                        rr_ptr      <= ~lane;
                        state       <= IDLE;
                    end
                end
                OPEN: begin
                    if (open_cnt == OPEN_W'(OPEN_CYCLES - 1)) begin
                        lane_open  <= '0;
                        lane_grant <= '0;
                        rr_ptr     <= ~lane;
                        state      <= IDLE;
                    end else begin
                        open_cnt <= open_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    parking_occupancy_ctr #(
        .CAPACITY(CAPACITY)
    ) u_occupancy (
        .clk       (clk),
        .reset     (reset),
        .inc       (admit),
        .dec       (exit_event),
        .free_slots(free_slots),
        .full      (full)
    );

`ifdef PARKING_LANE_ARBITER_STATS_EN
    // Saturating reject counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            reject_count <= '0;
            timeout_seen <= 1'b0;
        end else begin
            if (reject_now && (reject_count != 8'hFF)) begin
                reject_count <= reject_count + 1'b1;
            end
            if (timed_out) begin
                timeout_seen <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_parking_lane_arbiter.sv
// tb_parking_lane_arbiter: directed and randomized checks of parking_lane_arbiter
// against a transaction-level model (occupancy as a clamped integer, round-robin
// pointer, fixed latencies). Optional macro PARKING_LANE_ARBITER_STATS_EN.
module tb_parking_lane_arbiter;

    localparam int CAP    = 8;
    localparam int OPEN_C = 4;
    localparam int TMO    = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] lane_req;
    logic       exit_event;
    logic       chk_start;
    logic       chk_lane;
    logic       chk_done;
    logic       chk_pass;
    logic [1:0] lane_grant;
    logic [1:0] lane_open;
    logic [1:0] lane_reject;
    logic [3:0] free_slots;
    logic       full;
`ifdef PARKING_LANE_ARBITER_STATS_EN
    logic [7:0] reject_count;
    logic       timeout_seen;
`endif

    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state
    int   occ_m     = 0;
    logic rr_m      = 1'b0;
    int   rejects_m = 0;
    bit   tmo_m     = 1'b0;
    bit   admit_now = 1'b0;

    always #5 clk = ~clk;

    parking_lane_arbiter #(
        .CAPACITY      (CAP),
        .OPEN_CYCLES   (OPEN_C),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lane_req   (lane_req),
        .exit_event (exit_event),
        .chk_start  (chk_start),
        .chk_lane   (chk_lane),
        .chk_done   (chk_done),
        .chk_pass   (chk_pass),
        .lane_grant (lane_grant),
        .lane_open  (lane_open),
        .lane_reject(lane_reject),
        .free_slots (free_slots),
        .full       (full)
`ifdef PARKING_LANE_ARBITER_STATS_EN
        ,
        .reject_count(reject_count),
        .timeout_seen(timeout_seen)
`endif
    );

    function automatic logic [1:0] oh(input logic l);
        return l ? 2'b10 : 2'b01;
    endfunction

    function automatic logic pick_lane(input logic [1:0] req);
        if (req[rr_m]) return rr_m;
        return ~rr_m;
    endfunction

    // Advance one clock; the model applies this cycle's admit/exit, then pulses clear.
    task automatic step();
        int nxt;
        nxt = occ_m + (admit_now ? 1 : 0) - (exit_event ? 1 : 0);
        if (nxt < 0) nxt = 0;
        if (nxt > CAP) nxt = CAP;
        occ_m = nxt;
        @(posedge clk);
        #1;
        admit_now  = 1'b0;
        exit_event = 1'b0;
        chk_done   = 1'b0;
        chk_pass   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        occ_m     = 0;
        rr_m      = 1'b0;
        rejects_m = 0;
        tmo_m     = 1'b0;
    endtask

    task automatic test_reset();
        lane_req   = 2'b00;
        exit_event = 1'b0;
        chk_done   = 1'b0;
        chk_pass   = 1'b0;
        do_reset();
        vectors++;
        if ({chk_start, chk_lane, lane_grant, lane_open, lane_reject, full} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 0",
                     {chk_start, chk_lane, lane_grant, lane_open, lane_reject, full});
        end
        vectors++;
        if (free_slots !== 4'(CAP)) begin
            miscompares++;
            $display("FAIL reset_free_slots: got %0d want %0d", free_slots, CAP);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_admit();
        lane_req = 2'b01;
        step();                                   // cycle C
        vectors++;
        if ({chk_start, chk_lane, lane_grant} !== {1'b1, 1'b0, 2'b01}) begin
            miscompares++;
            $display("FAIL admit_start: got %b want 1001", {chk_start, chk_lane, lane_grant});
        end
        lane_req = 2'b00;                         // drop mid-check
        step();
        step();                                   // C+2
        vectors++;
        if ({chk_start, lane_grant, lane_open} !== {1'b0, 2'b01, 2'b00}) begin
            miscompares++;
            $display("FAIL admit_wait: got %b want 00100", {chk_start, lane_grant, lane_open});
        end
        step();                                   // C+3
        chk_done  = 1'b1;
        chk_pass  = 1'b1;
        admit_now = 1'b1;
        step();                                   // C+4
        vectors++;
        if (free_slots !== 4'(CAP - 1)) begin
            miscompares++;
            $display("FAIL admit_free_slots: got %0d want %0d", free_slots, CAP - 1);
        end
        for (int i = 0; i < OPEN_C; i++) begin
            vectors++;
            if (lane_open !== 2'b01 || lane_grant !== 2'b01) begin
                miscompares++;
                $display("FAIL admit_open_hold[%0d]: got open=%b grant=%b want 01/01",
                         i, lane_open, lane_grant);
            end
            step();
        end
        vectors++;
        if (lane_open !== 2'b00 || lane_grant !== 2'b00) begin
            miscompares++;
            $display("FAIL admit_open_end: got open=%b grant=%b want 00/00", lane_open, lane_grant);
        end
        rr_m = 1'b1;
    endtask

    task automatic test_round_robin();
        int   w;
        logic e;
        do_reset();
        reset    = 1'b0;
        step();
        lane_req = 2'b11;
        for (int t = 0; t < 2; t++) begin
            e = pick_lane(lane_req);
            w = 0;
            while (chk_start !== 1'b1 && w < 4) begin
                step();
                w++;
            end
            vectors++;
            if (w != 1 || chk_lane !== e || lane_grant !== oh(e)) begin
                miscompares++;
                $display("FAIL rr_grant[%0d]: got wait=%0d lane=%b grant=%b want 1/%b/%b",
                         t, w, chk_lane, lane_grant, e, oh(e));
            end
            vectors++;
            if (e !== logic'(t)) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: got lane %b want %0d", t, e, t);
            end
            step();
            step();
            chk_done  = 1'b1;
            chk_pass  = 1'b1;
            admit_now = 1'b1;
            step();
            repeat (OPEN_C) step();
            rr_m = ~e;
        end
        lane_req = 2'b00;
        step();
        step();
    endtask

    task automatic test_fail_timeout();
        int n;
        // Fail result
        lane_req = 2'b01;
        step();
        lane_req = 2'b00;
        step();
        chk_done = 1'b1;
        chk_pass = 1'b0;
        step();
        vectors++;
        if (lane_reject !== 2'b01 || lane_grant !== 2'b00 || free_slots !== 4'(CAP - occ_m)) begin
            miscompares++;
            $display("FAIL fail_reject: got rej=%b grant=%b free=%0d want 01/00/%0d",
                     lane_reject, lane_grant, free_slots, CAP - occ_m);
        end
        step();
        vectors++;
        if (lane_reject !== 2'b00) begin
            miscompares++;
            $display("FAIL fail_pulse_width: got %b want 00", lane_reject);
        end
        rejects_m++;
        rr_m = 1'b1;
        // Timeout with no chk_done
        lane_req = 2'b10;
        step();
        lane_req = 2'b00;
        n = 0;
        while (lane_reject === 2'b00 && n < TMO + 8) begin
            step();
            n++;
        end
        vectors++;
        if (n != TMO || lane_reject !== 2'b10) begin
            miscompares++;
            $display("FAIL timeout_reject: got %0d cycles rej=%b want %0d/10", n, lane_reject, TMO);
        end
        rejects_m++;
        tmo_m = 1'b1;
        rr_m  = 1'b0;
        step();
        // chk_done in the last cycle before the timeout still wins
        lane_req = 2'b01;
        step();
        lane_req = 2'b00;
        repeat (TMO - 1) step();
        vectors++;
        if (lane_reject !== 2'b00 || lane_grant !== 2'b01) begin
            miscompares++;
            $display("FAIL late_done_window: got rej=%b grant=%b want 00/01", lane_reject, lane_grant);
        end
        chk_done  = 1'b1;
        chk_pass  = 1'b1;
        admit_now = 1'b1;
        step();
        vectors++;
        if (lane_open !== 2'b01 || lane_reject !== 2'b00 || free_slots !== 4'(CAP - occ_m)) begin
            miscompares++;
            $display("FAIL late_done_wins: got open=%b rej=%b free=%0d want 01/00/%0d",
                     lane_open, lane_reject, free_slots, CAP - occ_m);
        end
        repeat (OPEN_C) step();
        rr_m = 1'b1;
    endtask

    task automatic test_full_lot();
        int starts;
        do_reset();
        reset = 1'b0;
        step();
        for (int k = 0; k < CAP; k++) begin
            lane_req = 2'b01;
            step();
            lane_req = 2'b00;
            step();
            chk_done  = 1'b1;
            chk_pass  = 1'b1;
            admit_now = 1'b1;
            step();
            repeat (OPEN_C) step();
        end
        rr_m = 1'b1;
        vectors++;
        if (full !== 1'b1 || free_slots !== 4'd0) begin
            miscompares++;
            $display("FAIL full_flag: got full=%b free=%0d want 1/0", full, free_slots);
        end
        lane_req = 2'b01;
        starts   = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (chk_start === 1'b1) starts++;
        end
        vectors++;
        if (starts != 0) begin
            miscompares++;
            $display("FAIL full_blocks_grant: got %0d chk_start pulses want 0", starts);
        end
        exit_event = 1'b1;
        step();
        vectors++;
        if (full !== 1'b0 || free_slots !== 4'd1) begin
            miscompares++;
            $display("FAIL exit_clears_full: got full=%b free=%0d want 0/1", full, free_slots);
        end
        step();
        vectors++;
        if (chk_start !== 1'b1 || chk_lane !== 1'b0) begin
            miscompares++;
            $display("FAIL pending_grant: got start=%b lane=%b want 1/0", chk_start, chk_lane);
        end
        lane_req = 2'b00;
        step();
        chk_done   = 1'b1;
        chk_pass   = 1'b1;
        admit_now  = 1'b1;
        exit_event = 1'b1;
        step();
        vectors++;
        if (lane_open !== 2'b01 || free_slots !== 4'd1 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL admit_with_exit: got open=%b free=%0d full=%b want 01/1/0",
                     lane_open, free_slots, full);
        end
        repeat (OPEN_C) step();
        rr_m = 1'b1;
    endtask

    task automatic test_exit_at_zero();
        do_reset();
        reset      = 1'b0;
        exit_event = 1'b1;
        step();
        exit_event = 1'b1;
        step();
        vectors++;
        if (free_slots !== 4'(CAP) || full !== 1'b0) begin
            miscompares++;
            $display("FAIL exit_underflow: got free=%0d full=%b want %0d/0", free_slots, full, CAP);
        end
    endtask

    task automatic test_reset_midway();
        // Reset while waiting for the checker
        lane_req = 2'b01;
        step();
        lane_req = 2'b00;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        occ_m = 0;
        rr_m  = 1'b0;
        rejects_m = 0;
        tmo_m = 1'b0;
        vectors++;
        if ({chk_start, chk_lane, lane_grant, lane_open, lane_reject, full} !== 9'd0 ||
            free_slots !== 4'(CAP)) begin
            miscompares++;
            $display("FAIL reset_in_wait: got %b free=%0d want 0/%0d",
                     {chk_start, chk_lane, lane_grant, lane_open, lane_reject, full}, free_slots, CAP);
        end
        chk_done = 1'b1;
        chk_pass = 1'b1;
        step();
        step();
        vectors++;
        if (lane_open !== 2'b00 || lane_grant !== 2'b00 || free_slots !== 4'(CAP)) begin
            miscompares++;
            $display("FAIL late_done_ignored: got open=%b grant=%b free=%0d want 00/00/%0d",
                     lane_open, lane_grant, free_slots, CAP);
        end
        // Reset while the barrier is open
        lane_req = 2'b10;
        step();
        lane_req = 2'b00;
        step();
        chk_done  = 1'b1;
        chk_pass  = 1'b1;
        admit_now = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        occ_m = 0;
        rr_m  = 1'b0;
        vectors++;
        if ({chk_start, chk_lane, lane_grant, lane_open, lane_reject, full} !== 9'd0 ||
            free_slots !== 4'(CAP)) begin
            miscompares++;
            $display("FAIL reset_in_open: got %b free=%0d want 0/%0d",
                     {chk_start, chk_lane, lane_grant, lane_open, lane_reject, full}, free_slots, CAP);
        end
        step();
    endtask

    task automatic test_random();
        logic [1:0] req;
        logic       e;
        int         kind;
        int         delay;
        int         n;
        bit         pass;
        for (int it = 0; it < 40; it++) begin
            vectors++;
            if (free_slots !== 4'(CAP - occ_m) || full !== (occ_m == CAP)) begin
                miscompares++;
                $display("FAIL rand_occupancy[%0d]: got free=%0d full=%b want %0d/%b",
                         it, free_slots, full, CAP - occ_m, occ_m == CAP);
            end
            if (occ_m == CAP) begin
                exit_event = 1'b1;
                step();
            end
            req      = 2'($urandom_range(1, 3));
            e        = pick_lane(req);
            lane_req = req;
            step();
            vectors++;
            if ({chk_start, chk_lane, lane_grant} !== {1'b1, e, oh(e)}) begin
                miscompares++;
                $display("FAIL rand_grant[%0d]: got %b want %b",
                         it, {chk_start, chk_lane, lane_grant}, {1'b1, e, oh(e)});
            end
            lane_req = 2'b00;
            kind     = $urandom_range(0, 9);
            delay    = $urandom_range(1, 6);
            n        = 0;
            if (kind == 0) begin
                while (lane_reject === 2'b00 && n < TMO + 8) begin
                    exit_event = ($urandom_range(0, 7) == 0);
                    step();
                    n++;
                end
                vectors++;
                if (n != TMO || lane_reject !== oh(e)) begin
                    miscompares++;
                    $display("FAIL rand_timeout[%0d]: got %0d cycles rej=%b want %0d/%b",
                             it, n, lane_reject, TMO, oh(e));
                end
                rejects_m++;
                tmo_m = 1'b1;
            end else begin
                for (int k = 0; k < delay; k++) begin
                    exit_event = ($urandom_range(0, 3) == 0);
                    step();
                end
                pass       = (kind > 3);
                chk_done   = 1'b1;
                chk_pass   = pass;
                admit_now  = pass;
                exit_event = ($urandom_range(0, 3) == 0);
                step();
                if (pass) begin
                    vectors++;
                    if (lane_open !== oh(e) || lane_reject !== 2'b00 || free_slots !== 4'(CAP - occ_m)) begin
                        miscompares++;
                        $display("FAIL rand_pass[%0d]: got open=%b rej=%b free=%0d want %b/00/%0d",
                                 it, lane_open, lane_reject, free_slots, oh(e), CAP - occ_m);
                    end
                    for (int k = 0; k < OPEN_C; k++) begin
                        exit_event = ($urandom_range(0, 3) == 0);
                        step();
                    end
                    vectors++;
                    if (lane_open !== 2'b00 || lane_grant !== 2'b00) begin
                        miscompares++;
                        $display("FAIL rand_open_end[%0d]: got open=%b grant=%b want 00/00",
                                 it, lane_open, lane_grant);
                    end
                end else begin
                    vectors++;
                    if (lane_reject !== oh(e) || lane_open !== 2'b00 || free_slots !== 4'(CAP - occ_m)) begin
                        miscompares++;
                        $display("FAIL rand_fail[%0d]: got rej=%b open=%b free=%0d want %b/00/%0d",
                                 it, lane_reject, lane_open, free_slots, oh(e), CAP - occ_m);
                    end
                    rejects_m++;
                end
            end
            rr_m = ~e;
            step();
        end
    endtask

`ifdef PARKING_LANE_ARBITER_STATS_EN
    task automatic test_stats();
        vectors++;
        if (reject_count !== 8'((rejects_m > 255) ? 255 : rejects_m) || timeout_seen !== tmo_m) begin
            miscompares++;
            $display("FAIL stats: got count=%0d tmo=%b want %0d/%b",
                     reject_count, timeout_seen, rejects_m, tmo_m);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_admit();
        test_round_robin();
        test_fail_timeout();
`ifdef PARKING_LANE_ARBITER_STATS_EN
        test_stats();
`endif
        test_full_lot();
        test_exit_at_zero();
        test_reset_midway();
        test_random();
`ifdef PARKING_LANE_ARBITER_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
